mem_responder: RTL and testbench
================================

Name: mem_responder

Overview:
Memory-side responder for the CPU control/datapath: the control unit is the initiator and drives the address from MAR, write data from ACC, and a request strobe; this block serves each request from internal RAM and returns read data for MDR load, or a write acknowledge. Fixed, parameterised wait states model slow memory, so the control FSM must hold in its fetch/execute step until the response arrives.

Parameters:
BITS, 8, data and address width; RAM depth is 2**BITS words
WAIT_STATES, 1, extra cycles between request acceptance and access (0..15)
WP_LIMIT, 16, addresses 0..WP_LIMIT-1 are write-protected (only when MEM_WPROT_EN is defined)

Ports:
i_clk  input  1  system clock, all state updates on rising edge
i_rst  input  1  asynchronous, active-high reset
i_req  input  1  request strobe from control; accepted only when o_ready=1
i_we   input  1  1=write, 0=read; sampled at acceptance only
i_addr  input  BITS  word address (from MAR); sampled at acceptance
i_wdata  input  BITS  write data (from ACC); sampled at acceptance
o_ready  output  1  high in IDLE only; request accepted on edge where i_req&&o_ready
o_rdata  output  BITS  read data; registered, holds last read value
o_rvalid  output  1  one-cycle pulse, o_rdata valid for MDR load
o_wack  output  1  one-cycle pulse, write completed
o_err  output  1  one-cycle pulse with o_wack on protected write (see Optional Feature)

Behaviour:
- Reset (async, i_rst=1): state=IDLE, wait counter=0, latched addr/data/we=0, o_rdata=0, o_rvalid=0, o_wack=0, o_err=0; o_ready=1. RAM contents not reset (zero at time 0 in simulation).
- o_ready is combinational from state (=IDLE); all other outputs registered.
- States: IDLE, WAIT, DONE.
- IDLE: on edge with i_req=1 -> latch i_addr, i_wdata, i_we; counter<=WAIT_STATES; go WAIT. i_req=0 -> stay.
- WAIT: counter!=0 -> counter-1, stay. counter==0 -> perform access on this edge: read sets o_rdata<=ram[addr], o_rvalid<=1; write sets ram[addr]<=wdata, o_wack<=1; go DONE.
- DONE: o_rvalid/o_wack high for this single cycle; next edge clears them, go IDLE.
- Latency: response pulse visible WAIT_STATES+1 cycles after accepting edge. Throughput: one request per WAIT_STATES+3 cycles (IDLE, WAIT..., DONE).
- i_req while not IDLE: ignored, not queued; initiator must re-assert after o_ready returns.
- i_addr/i_wdata/i_we changes after acceptance have no effect on the in-flight request.
- Address space full 2**BITS; no out-of-range case, no wrap logic needed.
- Read-after-write to same address returns the new value (write completes before next acceptance).
- Reset mid-operation: in-flight request aborted; a write not yet performed (still in WAIT) never reaches RAM; pulses cleared immediately.
- Illegal state encoding: return to IDLE on next edge, outputs cleared.
- WAIT_STATES counter width 4 bits; values >15 are a configuration error (elaboration assertion).

Optional Feature:
MEM_WPROT_EN: when defined, a write with latched addr < WP_LIMIT does not modify RAM; o_wack and o_err pulse together in DONE. Reads are never protected. When undefined, all writes are performed, o_err is tied 0, WP_LIMIT unused.

Test Plan:
- Reset: assert i_rst mid-cycle with i_req=1 -> o_ready=1, o_rvalid=o_wack=o_err=0, o_rdata=8'h00 immediately (async), no acceptance while i_rst=1.
- Write then read, WAIT_STATES=1: write 8'hA5 to 8'h20, then read 8'h20 -> o_wack 2 cycles after accept; o_rvalid 2 cycles after read accept with o_rdata=8'hA5; o_ready low for 3 cycles per request.
- WAIT_STATES=0 and 3: read 8'h20 -> o_rvalid exactly 1 and 4 cycles after accepting edge respectively.
- Busy ignore: accept read of 8'h10, pulse i_req with write 8'hFF to 8'h10 during WAIT -> no second response, ram[8'h10] unchanged; changing i_addr to 8'h11 during WAIT does not alter returned data.
- Reset mid-write: accept write 8'h3C to 8'h40 (WAIT_STATES=3), assert i_rst after 1 cycle -> later read 8'h40 returns prior value (8'h00).
- MEM_WPROT_EN, WP_LIMIT=16: write 8'h77 to 8'h05 -> o_wack=1 and o_err=1 same cycle, read 8'h05 returns 8'h00; write 8'h77 to 8'h10 -> o_err=0, read returns 8'h77; without macro, write to 8'h05 succeeds, o_err stays 0.

Source files
------------

// File: rtl/mem_responder_if.sv
// rtl/mem_responder_if.sv - request/response bus between the control unit and mem_responder
interface mem_responder_if #(
  parameter int BITS = 8
);
  logic            i_req;
  logic            i_we;
  logic [BITS-1:0] i_addr;
  logic [BITS-1:0] i_wdata;
  logic            o_ready;
  logic [BITS-1:0] o_rdata;
  logic            o_rvalid;
  logic            o_wack;
  logic            o_err;

  modport master (
    output i_req, i_we, i_addr, i_wdata,
    input  o_ready, o_rdata, o_rvalid, o_wack, o_err
  );

  modport slave (
    input  i_req, i_we, i_addr, i_wdata,
    output o_ready, o_rdata, o_rvalid, o_wack, o_err
  );
endinterface

// File: rtl/mem_responder.sv
// rtl/mem_responder.sv - wait-state RAM responder for the control unit; MEM_WPROT_EN enables low-address write protection
module mem_responder #(
  parameter int BITS        = 8,
  parameter int WAIT_STATES = 1,
  parameter int WP_LIMIT    = 16
) (
  input logic           i_clk,
  input logic           i_rst,
  mem_responder_if.slave bus
);

  if (WAIT_STATES < 0 || WAIT_STATES > 15) begin : g_bad_wait_states
    $error("mem_responder: WAIT_STATES must be in 0..15");
  end

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_WAIT = 2'd1,
    S_DONE = 2'd2
  } state_t;

  state_t          state_q, state_d;
  logic [3:0]      cnt_q, cnt_d;
  logic [BITS-1:0] addr_q, addr_d;
  logic [BITS-1:0] wdata_q, wdata_d;
  logic            we_q, we_d;
  logic [BITS-1:0] rdata_q, rdata_d;
  logic            rvalid_q, rvalid_d;
  logic            wack_q, wack_d;
  logic            err_q, err_d;
  logic            ram_we;
  logic            wp_hit;

  logic [BITS-1:0] ram_q [2**BITS];

`ifdef MEM_WPROT_EN
  localparam bit WPROT = 1'b1;
`else
  localparam bit WPROT = 1'b0;
`endif

  assign wp_hit = WPROT && (32'(addr_q) < WP_LIMIT);

  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    addr_d   = addr_q;
    wdata_d  = wdata_q;
    we_d     = we_q;
    rdata_d  = rdata_q;
    rvalid_d = 1'b0;
    wack_d   = 1'b0;
    err_d    = 1'b0;
    ram_we   = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (bus.i_req) begin
          addr_d  = bus.i_addr;
          wdata_d = bus.i_wdata;
          we_d    = bus.i_we;
          cnt_d   = 4'(WAIT_STATES);
          state_d = S_WAIT;
        end
      end
      S_WAIT: begin
        if (cnt_q != 4'd0) begin
          cnt_d = cnt_q - 4'd1;
        end else begin
          // The access happens on the edge that leaves WAIT, so a reset
          // anywhere inside WAIT keeps a pending write out of the RAM.
          if (we_q) begin
            wack_d = 1'b1;
            err_d  = wp_hit;
            ram_we = !wp_hit;
          end else begin
            rdata_d  = ram_q[addr_q];
            rvalid_d = 1'b1;
          end
          state_d = S_DONE;
        end
      end
      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      state_q  <= S_IDLE;
      cnt_q    <= '0;
      addr_q   <= '0;
      wdata_q  <= '0;
      we_q     <= 1'b0;
      rdata_q  <= '0;
      rvalid_q <= 1'b0;
      wack_q   <= 1'b0;
      err_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      addr_q   <= addr_d;
      wdata_q  <= wdata_d;
      we_q     <= we_d;
      rdata_q  <= rdata_d;
      rvalid_q <= rvalid_d;
      wack_q   <= wack_d;
      err_q    <= err_d;
    end
  end

  always_ff @(posedge i_clk) begin
    if (ram_we) begin
      ram_q[addr_q] <= wdata_q;
    end
  end

  assign bus.o_ready  = (state_q == S_IDLE);
  assign bus.o_rdata  = rdata_q;
  assign bus.o_rvalid = rvalid_q;
  assign bus.o_wack   = wack_q;
  assign bus.o_err    = err_q;

endmodule

// File: tb/tb_mem_responder.sv
// tb/tb_mem_responder.sv - randomized self-checking bench for mem_responder at WAIT_STATES 1, 0 and 3
module tb_mem_responder;

  localparam int WP_LIMIT = 16;
`ifdef MEM_WPROT_EN
  localparam bit PROT = 1'b1;
`else
  localparam bit PROT = 1'b0;
`endif

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  logic       req_a [3];
  logic       we_a [3];
  logic [7:0] addr_a [3];
  logic [7:0] wdata_a [3];
  logic       ready_a [3];
  logic       rvalid_a [3];
  logic       wack_a [3];
  logic       err_a [3];
  logic [7:0] rdata_a [3];

  logic [7:0] mdl [3][256];
  int n_checks = 0;
  int n_fail = 0;

  mem_responder_if #(.BITS(8)) bus0 ();
  mem_responder_if #(.BITS(8)) bus1 ();
  mem_responder_if #(.BITS(8)) bus2 ();

  assign bus0.i_req = req_a[0];  assign bus0.i_we = we_a[0];
  assign bus0.i_addr = addr_a[0]; assign bus0.i_wdata = wdata_a[0];
  assign bus1.i_req = req_a[1];  assign bus1.i_we = we_a[1];
  assign bus1.i_addr = addr_a[1]; assign bus1.i_wdata = wdata_a[1];
  assign bus2.i_req = req_a[2];  assign bus2.i_we = we_a[2];
  assign bus2.i_addr = addr_a[2]; assign bus2.i_wdata = wdata_a[2];

  assign ready_a[0] = bus0.o_ready; assign rvalid_a[0] = bus0.o_rvalid; assign wack_a[0] = bus0.o_wack;
  assign err_a[0] = bus0.o_err;     assign rdata_a[0] = bus0.o_rdata;
  assign ready_a[1] = bus1.o_ready; assign rvalid_a[1] = bus1.o_rvalid; assign wack_a[1] = bus1.o_wack;
  assign err_a[1] = bus1.o_err;     assign rdata_a[1] = bus1.o_rdata;
  assign ready_a[2] = bus2.o_ready; assign rvalid_a[2] = bus2.o_rvalid; assign wack_a[2] = bus2.o_wack;
  assign err_a[2] = bus2.o_err;     assign rdata_a[2] = bus2.o_rdata;

  mem_responder #(.BITS(8), .WAIT_STATES(1), .WP_LIMIT(WP_LIMIT)) dut0 (.i_clk(clk), .i_rst(rst), .bus(bus0.slave));
  mem_responder #(.BITS(8), .WAIT_STATES(0), .WP_LIMIT(WP_LIMIT)) dut1 (.i_clk(clk), .i_rst(rst), .bus(bus1.slave));
  mem_responder #(.BITS(8), .WAIT_STATES(3), .WP_LIMIT(WP_LIMIT)) dut2 (.i_clk(clk), .i_rst(rst), .bus(bus2.slave));

  function automatic int ws_of(input int d);
    case (d)
      0:       return 1;
      1:       return 0;
      default: return 3;
    endcase
  endfunction

  function automatic bit prot_hit(input logic [7:0] a);
    return PROT && (int'(a) < WP_LIMIT);
  endfunction

  task automatic model_write(input int d, input logic [7:0] a, input logic [7:0] wd);
    if (!prot_hit(a)) mdl[d][a] = wd;
  endtask

  // One request from the idle point (#1 after an edge); reports what the bus did.
  task automatic xact(input int d, input bit w, input logic [7:0] a, input logic [7:0] wd, input bit hold,
                      output int lat, output int busy, output bit got_rv, output bit got_wk,
                      output logic [7:0] rd, output bit err, output bit extra);
    bit seen;
    req_a[d] = 1'b1; we_a[d] = w; addr_a[d] = a; wdata_a[d] = wd;
    @(posedge clk); #1;
    if (hold) begin
      we_a[d] = 1'b1; addr_a[d] = a + 8'd1; wdata_a[d] = 8'hFF;
    end else begin
      req_a[d] = 1'b0; we_a[d] = 1'($urandom); addr_a[d] = 8'($urandom); wdata_a[d] = 8'($urandom);
    end
    lat = -1; busy = ready_a[d] ? 0 : 1; got_rv = 0; got_wk = 0; rd = '0; err = 0; seen = 0;
    for (int n = 1; n <= 40 && !seen; n++) begin
      @(posedge clk); #1;
      if (!ready_a[d]) busy++;
      if (rvalid_a[d] || wack_a[d]) begin
        seen = 1; lat = n; got_rv = rvalid_a[d]; got_wk = wack_a[d]; rd = rdata_a[d]; err = err_a[d];
      end
    end
    req_a[d] = 1'b0;
    @(posedge clk); #1;
    if (!ready_a[d]) busy++;
    extra = rvalid_a[d] | wack_a[d] | err_a[d];
  endtask

  task automatic test_reset();
    int lat, busy; bit rv, wk, er, ex; logic [7:0] rd;
    n_checks++;
    if ({ready_a[0], rvalid_a[0], wack_a[0], err_a[0], rdata_a[0]} !== {1'b1, 3'b000, 8'h00}) begin
      n_fail++; $display("FAIL reset_state: got rdy/rv/wk/err/rdata=%b%b%b%b/%h want 1000/00",
                         ready_a[0], rvalid_a[0], wack_a[0], err_a[0], rdata_a[0]);
    end
    rst = 1'b0;
    @(posedge clk); #1;
    xact(0, 1'b1, 8'h30, 8'h99, 1'b0, lat, busy, rv, wk, rd, er, ex);
    model_write(0, 8'h30, 8'h99);
    xact(0, 1'b0, 8'h30, 8'h00, 1'b0, lat, busy, rv, wk, rd, er, ex);
    n_checks++;
    if (rd !== 8'h99) begin n_fail++; $display("FAIL reset_pre_read: got %h want 99", rd); end
    req_a[0] = 1'b1; we_a[0] = 1'b0; addr_a[0] = 8'h30;
    @(posedge clk); #3;
    rst = 1'b1;
    #1;
    n_checks++;
    if ({ready_a[0], rvalid_a[0], wack_a[0], err_a[0], rdata_a[0]} !== {1'b1, 3'b000, 8'h00}) begin
      n_fail++; $display("FAIL reset_async: got rdy/rv/wk/err/rdata=%b%b%b%b/%h want 1000/00",
                         ready_a[0], rvalid_a[0], wack_a[0], err_a[0], rdata_a[0]);
    end
    for (int i = 0; i < 3; i++) begin
      @(posedge clk); #1;
      n_checks++;
      if (ready_a[0] !== 1'b1 || rvalid_a[0] !== 1'b0) begin
        n_fail++; $display("FAIL reset_hold_accept: got ready=%b rvalid=%b want 1/0", ready_a[0], rvalid_a[0]);
      end
    end
    req_a[0] = 1'b0; rst = 1'b0;
    @(posedge clk); #1;
  endtask

  task automatic test_write_read();
    int lat, busy; bit rv, wk, er, ex; logic [7:0] rd;
    xact(0, 1'b1, 8'h20, 8'hA5, 1'b0, lat, busy, rv, wk, rd, er, ex);
    model_write(0, 8'h20, 8'hA5);
    n_checks++;
    if ({wk, rv, ex} !== 3'b100 || lat !== 2 || busy !== 3) begin
      n_fail++; $display("FAIL wr_resp: got wk/rv/extra=%b%b%b lat=%0d busy=%0d want 100 lat=2 busy=3", wk, rv, ex, lat, busy);
    end
    xact(0, 1'b0, 8'h20, 8'h00, 1'b0, lat, busy, rv, wk, rd, er, ex);
    n_checks++;
    if ({rv, wk, ex} !== 3'b100 || lat !== 2 || busy !== 3 || rd !== 8'hA5) begin
      n_fail++; $display("FAIL rd_resp: got rv/wk/extra=%b%b%b lat=%0d busy=%0d rdata=%h want 100 lat=2 busy=3 a5",
                         rv, wk, ex, lat, busy, rd);
    end
  endtask

  task automatic test_latency();
    int lat, busy; bit rv, wk, er, ex; logic [7:0] rd;
    for (int d = 1; d <= 2; d++) begin
      xact(d, 1'b1, 8'h20, 8'hA5, 1'b0, lat, busy, rv, wk, rd, er, ex);
      model_write(d, 8'h20, 8'hA5);
      xact(d, 1'b0, 8'h20, 8'h00, 1'b0, lat, busy, rv, wk, rd, er, ex);
      n_checks++;
      if (rv !== 1'b1 || lat !== ws_of(d) + 1 || busy !== ws_of(d) + 2 || rd !== 8'hA5) begin
        n_fail++; $display("FAIL latency_ws%0d: got rv=%b lat=%0d busy=%0d rdata=%h want 1 lat=%0d busy=%0d a5",
                           ws_of(d), rv, lat, busy, rd, ws_of(d) + 1, ws_of(d) + 2);
      end
    end
  endtask

  task automatic test_busy_ignore();
    int lat, busy; bit rv, wk, er, ex, stray; logic [7:0] rd;
    xact(0, 1'b1, 8'h10, 8'h5A, 1'b0, lat, busy, rv, wk, rd, er, ex);
    model_write(0, 8'h10, 8'h5A);
    xact(0, 1'b1, 8'h11, 8'hC3, 1'b0, lat, busy, rv, wk, rd, er, ex);
    model_write(0, 8'h11, 8'hC3);
    xact(0, 1'b0, 8'h10, 8'h00, 1'b1, lat, busy, rv, wk, rd, er, ex);
    n_checks++;
    if ({rv, wk, ex} !== 3'b100 || lat !== 2 || rd !== mdl[0][8'h10]) begin
      n_fail++; $display("FAIL busy_read: got rv/wk/extra=%b%b%b lat=%0d rdata=%h want 100 lat=2 %h",
                         rv, wk, ex, lat, rd, mdl[0][8'h10]);
    end
    stray = 0;
    for (int i = 0; i < 6; i++) begin
      @(posedge clk); #1;
      stray |= rvalid_a[0] | wack_a[0] | !ready_a[0];
    end
    n_checks++;
    if (stray !== 1'b0) begin n_fail++; $display("FAIL busy_no_second: got activity=%b want 0", stray); end
    xact(0, 1'b0, 8'h10, 8'h00, 1'b0, lat, busy, rv, wk, rd, er, ex);
    n_checks++;
    if (rd !== 8'h5A) begin n_fail++; $display("FAIL busy_ram_kept: got %h want 5a", rd); end
  endtask

  task automatic test_reset_mid_write();
    int lat, busy; bit rv, wk, er, ex; logic [7:0] rd;
    xact(2, 1'b1, 8'h40, 8'h00, 1'b0, lat, busy, rv, wk, rd, er, ex);
    model_write(2, 8'h40, 8'h00);
    req_a[2] = 1'b1; we_a[2] = 1'b1; addr_a[2] = 8'h40; wdata_a[2] = 8'h3C;
    @(posedge clk); #1;
    req_a[2] = 1'b0;
    @(posedge clk); #1;
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    for (int i = 0; i < 5; i++) begin @(posedge clk); #1; end
    n_checks++;
    if (ready_a[2] !== 1'b1 || wack_a[2] !== 1'b0) begin
      n_fail++; $display("FAIL abort_idle: got ready=%b wack=%b want 1/0", ready_a[2], wack_a[2]);
    end
    xact(2, 1'b0, 8'h40, 8'h00, 1'b0, lat, busy, rv, wk, rd, er, ex);
    n_checks++;
    if (rv !== 1'b1 || rd !== 8'h00) begin
      n_fail++; $display("FAIL abort_no_write: got rv=%b rdata=%h want 1 00", rv, rd);
    end
  endtask

  task automatic test_wprot();
    int lat, busy; bit rv, wk, er, ex; logic [7:0] rd;
    logic [7:0] addrs [2];
    addrs[0] = 8'h05; addrs[1] = 8'h10;
    foreach (addrs[i]) begin
      xact(0, 1'b1, addrs[i], 8'h77, 1'b0, lat, busy, rv, wk, rd, er, ex);
      model_write(0, addrs[i], 8'h77);
      n_checks++;
      if (wk !== 1'b1 || er !== prot_hit(addrs[i]) || ex !== 1'b0) begin
        n_fail++; $display("FAIL wprot_resp_%h: got wack=%b err=%b extra=%b want 1 %b 0",
                           addrs[i], wk, er, ex, prot_hit(addrs[i]));
      end
      xact(0, 1'b0, addrs[i], 8'h00, 1'b0, lat, busy, rv, wk, rd, er, ex);
      n_checks++;
      if (rd !== mdl[0][addrs[i]] || er !== 1'b0) begin
        n_fail++; $display("FAIL wprot_read_%h: got rdata=%h err=%b want %h 0", addrs[i], rd, er, mdl[0][addrs[i]]);
      end
    end
  endtask

  task automatic test_random();
    int lat, busy; bit rv, wk, er, ex, w; logic [7:0] rd, a, wd;
    for (int d = 0; d < 3; d++) begin
      for (int k = 0; k < 16; k++) begin
        wd = 8'($urandom);
        xact(d, 1'b1, 8'(8'h80 + k), wd, 1'b0, lat, busy, rv, wk, rd, er, ex);
        model_write(d, 8'(8'h80 + k), wd);
      end
      for (int k = 0; k < 30; k++) begin
        w  = 1'($urandom);
        a  = 8'($urandom_range(0, 15)) | ($urandom_range(0, 3) != 0 ? 8'h80 : 8'h00);
        wd = 8'($urandom);
        xact(d, w, a, wd, 1'b0, lat, busy, rv, wk, rd, er, ex);
        n_checks++;
        if (w ? ({wk, rv, er} !== {2'b10, prot_hit(a)}) : ({rv, wk, er} !== 3'b100 || rd !== mdl[d][a])) begin
          n_fail++; $display("FAIL rand_d%0d_%0d: we=%b addr=%h got rv/wk/err=%b%b%b rdata=%h want rdata %h err %b",
                             d, k, w, a, rv, wk, er, rd, mdl[d][a], w && prot_hit(a));
        end
        n_checks++;
        if (lat !== ws_of(d) + 1 || busy !== ws_of(d) + 2 || ex !== 1'b0) begin
          n_fail++; $display("FAIL rand_timing_d%0d_%0d: got lat=%0d busy=%0d extra=%b want %0d %0d 0",
                             d, k, lat, busy, ex, ws_of(d) + 1, ws_of(d) + 2);
        end
        if (w) model_write(d, a, wd);
      end
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    rst = 1'b1;
    for (int d = 0; d < 3; d++) begin
      req_a[d] = 1'b0; we_a[d] = 1'b0; addr_a[d] = '0; wdata_a[d] = '0;
      for (int k = 0; k < 256; k++) mdl[d][k] = 8'h00;
    end
    @(posedge clk); #1;
    test_reset();
    test_write_read();
    test_latency();
    test_busy_ignore();
    test_reset_mid_write();
    test_wprot();
    test_random();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
